// File: rtl/dmem_pkg.sv
// Shared types for the data-memory stage: FSM states, op encoding and counter width.
// Imported by the top-level data_mem_unit.
package dmem_pkg;

    localparam int LATW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } op_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write port and a registered read port sharing one index.
// Latency: 1 cycle from re to rData; rData holds between reads and clears on reset.
module dmem_array #(
    parameter int n = 32,
    parameter int a = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic         re,
    input  logic [a-1:0] idx,
    input  logic [n-1:0] wData,
    output logic [n-1:0] rData
);

    logic [n-1:0] mem [2**a];

    // Storage is deliberately not reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rData <= '0;
        end else if (re) begin
            rData <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory behind the single-cycle datapath; each access occupies LAT+2 cycles.
// stall holds the PC/register file from issue through the last ACCESS cycle.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int n   = 32,
    parameter int a   = 10,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writeData,
    output logic [n-1:0] readData,
    output logic         stall,
    output logic         misaligned,
    output logic         busy
);

    state_t         state;
    logic [LATW-1:0] count;
    logic [a-1:0]   capIdx;
    logic [n-1:0]   capData;
    op_t            capOp;

    logic req;
    logic aligned;
    logic issue;
    logic lastAccess;
    logic unusedAddrBits;

    assign req        = memRead | memWrite;
    assign aligned    = (addr[1:0] == 2'b00);
    assign issue      = (state == IDLE) && req && aligned;
    assign lastAccess = (state == ACCESS) && (count == '0);

    // Upper address bits fall outside the array, giving modulo-2^(a+2) wrap.
    assign unusedAddrBits = ^addr[n-1:a+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            capIdx  <= '0;
            capData <= '0;
            capOp   <= OP_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= ACCESS;
                        count   <= LATW'(LAT - 1);
                        capIdx  <= addr[a+1:2];
                        capData <= writeData;
                        capOp   <= memWrite ? OP_STORE : OP_LOAD;
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    // Requests here belong to the instruction that just completed.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .n(n),
        .a(a)
    ) uArray (
        .clk  (clk),
        .reset(reset),
        .we   (lastAccess && (capOp == OP_STORE)),
        .re   (lastAccess && (capOp == OP_LOAD)),
        .idx  (capIdx),
        .wData(capData),
        .rData(readData)
    );

    assign stall      = !reset && (issue || (state == ACCESS));
    assign misaligned = !reset && (state == IDLE) && req && !aligned;
    assign busy       = (state != IDLE);

endmodule
